// File: rtl/candidate_topk_ctrl.sv
// Keeps a sorted list of the best K (theta, phi) candidates seen during a search stage and
// sequences the end of the stage: collect, flush pipeline stragglers, then pulse sorted_rdy.
module candidate_topk_ctrl #(
  parameter int unsigned ANGLE_W   = 12,
  parameter int unsigned SCORE_W   = 16,
  parameter int unsigned K_MAX     = 10,
  parameter int unsigned FLUSH_CYC = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [3:0]                     compare_num,
  input  logic                           score_valid,
  input  logic [SCORE_W-1:0]             score,
  input  logic [ANGLE_W-1:0]             score_theta,
  input  logic [ANGLE_W-1:0]             score_phi,
  input  logic                           stage_done,
  output logic                           busy,
  output logic                           sorted_rdy,
  output logic [2*ANGLE_W*K_MAX-1:0]     candidate_angle_buffer,
  output logic [3:0]                     cand_count,
  output logic [SCORE_W-1:0]             best_score
);

  localparam int unsigned AngW = 2 * ANGLE_W;
  localparam int unsigned CntW = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);
  localparam logic [3:0] KMax = 4'(K_MAX);
  localparam logic [CntW-1:0] FlushInit = CntW'(FLUSH_CYC);

  typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          k_q, k_d;
  logic [3:0]          count_q, count_d;
  logic [CntW-1:0]     flush_q, flush_d;
  logic [AngW-1:0]     ang_q [K_MAX];
  logic [AngW-1:0]     ang_d [K_MAX];
  logic [SCORE_W-1:0]  sc_q  [K_MAX];
  logic [SCORE_W-1:0]  sc_d  [K_MAX];

  logic                accept;
  logic                insert;
  logic [4:0]          pos;
  logic [AngW-1:0]     new_ang;

  assign new_ang = {score_theta, score_phi};
  assign accept  = score_valid && !clear && (state_q == StCollect || state_q == StFlush);
  assign insert  = accept && (pos < {1'b0, k_q});

  // The list is kept sorted, so counting ">=" entries gives the insertion slot; ties keep
  // the earlier arrival ahead of the new score.
  always_comb begin
    pos = '0;
    for (int i = 0; i < K_MAX; i++) begin
      if (4'(i) < count_q && sc_q[i] >= score) begin
        pos = pos + 5'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    k_d     = k_q;
    if (clear) begin
      state_d = StCollect;
      if (compare_num == 4'd0) begin
        k_d = 4'd1;
      end else if (compare_num > KMax) begin
        k_d = KMax;
      end else begin
        k_d = compare_num;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StCollect: begin
          if (stage_done) begin
            state_d = StFlush;
            flush_d = FlushInit;
          end
        end
        StFlush: begin
          if (flush_q == CntW'(1)) begin
            state_d = StDone;
          end else begin
            flush_d = flush_q - CntW'(1);
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    for (int i = 0; i < K_MAX; i++) begin
      ang_d[i] = ang_q[i];
      sc_d[i]  = sc_q[i];
    end
    if (clear) begin
      count_d = '0;
      for (int i = 0; i < K_MAX; i++) begin
        ang_d[i] = '0;
        sc_d[i]  = '0;
      end
    end else if (insert) begin
      if (pos == 5'd0) begin
        ang_d[0] = new_ang;
        sc_d[0]  = score;
      end
      for (int i = 1; i < K_MAX; i++) begin
        if (4'(i) < k_q) begin
          if (5'(i) == pos) begin
            ang_d[i] = new_ang;
            sc_d[i]  = score;
          end else if (5'(i) > pos) begin
            ang_d[i] = ang_q[i-1];
            sc_d[i]  = sc_q[i-1];
          end
        end
      end
      count_d = (count_q < k_q) ? count_q + 4'd1 : k_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= 4'd1;
      count_q <= '0;
      flush_q <= '0;
      for (int i = 0; i < K_MAX; i++) begin
        ang_q[i] <= '0;
        sc_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      count_q <= count_d;
      flush_q <= flush_d;
      for (int i = 0; i < K_MAX; i++) begin
        ang_q[i] <= ang_d[i];
        sc_q[i]  <= sc_d[i];
      end
    end
  end

  always_comb begin
    busy       = (state_q == StCollect) || (state_q == StFlush);
    sorted_rdy = (state_q == StDone);
    cand_count = count_q;
    best_score = (count_q != 4'd0) ? sc_q[0] : '0;
    candidate_angle_buffer = '0;
    for (int i = 0; i < K_MAX; i++) begin
      if (4'(i) < count_q) begin
        candidate_angle_buffer[i*AngW +: AngW] = ang_q[i];
      end
    end
  end

endmodule

// File: doc/candidate_topk_ctrl.md
# candidate_topk_ctrl

Collects the per-angle match scores produced during one search stage and keeps a sorted list of the best `compare_num` (theta, phi) candidates. It also sequences the end of the stage. After the angle sweep signals completion, the block waits for the score pipeline to drain, then pulses `sorted_rdy`. The state machine uses that pulse to advance to the next stage, and it reads the refined search windows from `candidate_angle_buffer`.

## Interface
- `ANGLE_W`, default 12: width of theta and of phi.
- `SCORE_W`, default 16: unsigned score width.
- `K_MAX`, default 10: maximum number of candidate slots.
- `FLUSH_CYC`, default 4: number of cycles the block waits for score-pipeline stragglers after `stage_done`.

Ports:
- `clk`  in  1  clock. One clock domain only; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `clear`  in  1  pulse. Empties the list, latches `compare_num` and enters COLLECT.
- `compare_num`  in  4  number of slots kept this stage. Sampled only when `clear` is high.
- `score_valid`  in  1  a score/angle triple is present this cycle.
- `score`  in  SCORE_W  match score; higher is better.
- `score_theta`  in  ANGLE_W  theta of the scored angle.
- `score_phi`  in  ANGLE_W  phi of the scored angle.
- `stage_done`  in  1  pulse. The last angle of the stage has been issued.
- `busy`  out  1  high in COLLECT and FLUSH.
- `sorted_rdy`  out  1  one-cycle pulse. The list is final.
- `candidate_angle_buffer`  out  2*ANGLE_W*K_MAX  slot i occupies bits [(i+1)*24-1 -: 24] and holds {theta, phi}. Slot 0 is the best.
- `cand_count`  out  4  number of valid slots.
- `best_score`  out  SCORE_W  score held in slot 0; 0 when the list is empty.

## Operation
- States: IDLE, COLLECT, FLUSH, DONE. Reset puts the block in IDLE.
- IDLE and DONE ignore `score_valid`.
- `clear` in any state → COLLECT.
  - All slots, all slot scores and `cand_count` go to 0.
  - K = clamp(`compare_num`, 1, K_MAX); a value of 0 becomes 1.
- COLLECT: accept one score per cycle. `stage_done` → FLUSH and loads the flush counter with FLUSH_CYC.
- FLUSH: scores are still accepted. The counter decrements each cycle; when it reaches 1, the next state is DONE.
- DONE: lasts one cycle with `sorted_rdy`=1, then → IDLE. The list is held in IDLE until the next `clear`.
- Insertion rule, evaluated in parallel over all slots:
  - p = number of valid slots whose score ≥ the new score. On ties, the earlier arrival ranks higher.
  - If p < K: write to slot p, shift slots p..K-2 down by one, and discard slot K-1's contents.
  - If p ≥ K: drop the score.
  - `cand_count` ← min(`cand_count`+1, K) whenever an insertion occurs.
- Slots at index ≥ `cand_count` output 0. Slots at index ≥ K are never written.
- Scores are unsigned. An all-zero score is a valid entry and occupies a slot.

## Timing
- Reset values: `busy`=0, `sorted_rdy`=0, `candidate_angle_buffer`=0, `cand_count`=0, `best_score`=0.
- A score accepted in cycle n is visible on the outputs in cycle n+1. Sustained throughput is 1 score/cycle with no backpressure.
- `stage_done` sampled in COLLECT in cycle n:
  - FLUSH occupies cycles n+1 .. n+FLUSH_CYC.
  - `sorted_rdy`=1 in cycle n+FLUSH_CYC+1; `busy`=0 in that cycle.
- A score in the same cycle as `stage_done` is accepted.
- A score in the last FLUSH cycle is accepted and is included when `sorted_rdy` is high.
- `clear` together with `score_valid`: `clear` wins and the score is dropped.
- `clear` together with `stage_done`: `clear` wins and the block stays in COLLECT.
- `stage_done` outside COLLECT is ignored.
- `clear` during FLUSH aborts the stage: no `sorted_rdy` is produced.
- `rst` has priority over all other inputs. After `rst`, `sorted_rdy` is 0 until a full clear → stage_done → flush sequence has completed.

## Test plan
1. Reset, then `clear` with `compare_num`=3. Send scores 5, 9, 7, 9, 1 with angles A–E → slots hold B, D, C, `cand_count`=3, `best_score`=9.
2. `compare_num`=1. Send 100 scores with random values → slot 0 holds the angle of the first occurrence of the maximum score; slots 1..9 are 0.
3. `stage_done` in cycle 20 with FLUSH_CYC=4, plus a score of 999 in cycle 24 → score accepted, `sorted_rdy` high only in cycle 25, slot 0 = angle of the 999 score.
4. `clear` with `compare_num`=0 and `compare_num`=15 → effective K is 1 and 10 respectively. With 12 distinct descending scores, `cand_count` saturates at 1 and 10.
5. `clear` asserted in FLUSH cycle 2 → no `sorted_rdy`, list empty, `busy`=1. A subsequent normal stage completes correctly.
6. `clear` in the same cycle as `score_valid` (score 50) → `cand_count`=0 in the next cycle. `rst` during COLLECT → all outputs return to their reset values in the next cycle.
